// File: rtl/if_fetch_queue.sv
// Instruction prefetch queue between IF and ID: circular buffer with first-word
// fall-through output, valid/ready push side and a redirect that drops all pending fetches.
package if_fetch_queue_pkg;
  typedef struct packed {
    logic addr_err;
    logic tlb_refill;
    logic tlb_invalid;
    logic bus_err;
  } ExceptinPipeType;

  typedef struct packed {
    logic [31:0]     instr;
    logic [31:0]     pc;
    ExceptinPipeType exc;
  } fq_entry_t;
endpackage

module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FQ_PushValid,
  output logic             FQ_PushReady,
  input  logic [31:0]      FQ_PushInstr,
  input  logic [31:0]      FQ_PushPC,
  input  ExceptinPipeType  FQ_PushExcept,
  input  logic             FQ_Redirect,
  input  logic             ID_Wr,
  input  logic             ID_Flush,
  output logic             IF_Valid,
  output logic [31:0]      IF_Instr,
  output logic [31:0]      IF_PC,
  output ExceptinPipeType  IF_ExceptType,
  output logic [CNT_W-1:0] FQ_Count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fq_entry_t        mem_q [DEPTH];
  fq_entry_t        head;
  logic             empty, full, push, pop;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    push     = FQ_PushValid && !full && !FQ_Redirect;
    pop      = ID_Wr && !ID_Flush && !empty && !FQ_Redirect;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (FQ_Redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; outputs are masked while empty instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: FQ_PushInstr, pc: FQ_PushPC, exc: FQ_PushExcept};
  end

  always_comb begin
    head          = mem_q[rd_ptr_q];
    FQ_PushReady  = !full;
    IF_Valid      = !empty;
    IF_Instr      = empty ? 32'b0 : head.instr;
    IF_PC         = empty ? 32'b0 : head.pc;
    IF_ExceptType = empty ? ExceptinPipeType'('0) : head.exc;
    FQ_Count      = count_q;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction prefetch buffer at the producer end of the IF→ID interface.
- Accepts fetched words (instr, PC, fetch exception) from the IF/I-cache side through a valid/ready handshake.
- Presents the oldest entry to the ID pipeline register as IF_Instr/IF_PC/IF_ExceptType and pops it when ID captures it.
- Decouples I-cache latency from ID stalls and discards all pending fetches on a redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-low reset; rst==0 at posedge clears all state.
- FQ_PushValid  in  1  fetch side presents a valid word.
- FQ_PushReady  out  1  queue can accept a word this cycle.
- FQ_PushInstr  in  32  fetched instruction.
- FQ_PushPC  in  32  PC of the fetched instruction.
- FQ_PushExcept  in  ExceptinPipeType  fetch-stage exception flags, carried unchanged.
- FQ_Redirect  in  1  branch/exception redirect; discards all entries.
- ID_Wr  in  1  ID register write enable; ID captures the head this cycle.
- ID_Flush  in  1  ID register flush; ID does not capture this cycle.
- IF_Valid  out  1  head entry valid.
- IF_Instr  out  32  head instruction; 32'b0 (nop) when empty.
- IF_PC  out  32  head PC; 32'b0 when empty.
- IF_ExceptType  out  ExceptinPipeType  head exception flags; '0 when empty.
- FQ_Count  out  CNT_W  current occupancy.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {instr, pc, except}. Read pointer rd_ptr and write pointer wr_ptr are log2(DEPTH) bits wide, increment by 1 and wrap modulo DEPTH. count holds 0..DEPTH.
- Reset (rst==0 at posedge): rd_ptr=0, wr_ptr=0, count=0. After reset: IF_Valid=0, IF_Instr=0, IF_PC=0, IF_ExceptType='0, FQ_Count=0, FQ_PushReady=1.
- Entry contents need no reset; outputs are masked to zero when empty.
- empty = (count==0); full = (count==DEPTH).
- FQ_PushReady = !full. It depends only on registered state; there is no combinational path from ID_Wr or FQ_Redirect.
- Output is first-word fall-through. IF_* shows entry[rd_ptr] combinationally whenever !empty; IF_Valid = !empty.
- A word pushed at edge N is visible on IF_* in the cycle after edge N (one-cycle latency).
- push = FQ_PushValid && FQ_PushReady && !FQ_Redirect.
- pop = ID_Wr && !ID_Flush && !empty && !FQ_Redirect.
- On push, write entry[wr_ptr] and advance wr_ptr. On pop, advance rd_ptr.
- Count update:
  - push only: count+1
  - pop only: count−1
  - push and pop together: count unchanged (valid when neither empty nor full)
- When full, a same-cycle pop does not enable a push (PushReady=0). The fetch side retries next cycle.
- ID_Wr while empty: no pop, state unchanged. ID captures the zero/nop bubble on IF_*.
- ID_Flush=1: no pop regardless of ID_Wr; the head is retained for the next ID_Wr.
- FQ_Redirect=1 (highest priority after reset): at the edge, rd_ptr=wr_ptr=0 and count=0. Any same-cycle push and pop are dropped.
  - Next cycle: IF_Valid=0 and FQ_PushReady=1.
- Reset mid-operation behaves exactly like power-on reset; pending entries are lost.
- Data is carried unchanged; the queue performs no decoding or exception merging.
- FQ_Count = count.

Test Plan:
- Reset: hold rst=0 for 2 cycles with FQ_PushValid=1 → IF_Valid=0, IF_Instr=0, IF_PC=0, FQ_Count=0, FQ_PushReady=1.
- Fill to full: ID_Wr=0, push PCs 0xBFC00000..0xBFC0000C (instr 0x24010001..4) → FQ_Count=4, FQ_PushReady=0; IF_PC=0xBFC00000 held; a 5th push is not accepted.
- Streaming with wrap: ID_Wr=1, push one word every cycle for 10 cycles starting from 2 queued → FQ_Count stays 2; IF_PC sequence strictly increments by 4 across pointer wrap; no loss or duplication.
- ID_Flush priority: queue holds PC 0x80000000 at head, ID_Wr=1 with ID_Flush=1 for one cycle → FQ_Count unchanged, head still 0x80000000; next cycle ID_Wr=1, ID_Flush=0 pops it.
- Redirect: 3 entries queued, FQ_Redirect=1 together with FQ_PushValid=1 and ID_Wr=1 → next cycle FQ_Count=0, IF_Valid=0, IF_Instr=0; pushing PC 0x80001000 afterwards appears at head one cycle later.
- Empty pop and exception carry: empty queue with ID_Wr=1 → state unchanged, outputs zero; push with FQ_PushExcept nonzero → same value appears on IF_ExceptType.
